// File: rtl/majority_repeat_tx_pkg.sv
// rtl/majority_repeat_tx_pkg.sv - shared state encoding and defaults for the repetition-code transmitter
package majority_repeat_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    localparam int DEF_SIZE     = 9;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAJORITY = (DEF_SIZE + 1) / 2;

    // A range of one still needs a one-bit counter to be a legal vector.
    function automatic int ctr_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/majority_repeat_ctr.sv
// rtl/majority_repeat_ctr.sv - rep_cnt/bit_idx counter pair with wrap and terminal-count flags
module majority_repeat_ctr
    import majority_repeat_tx_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic rep_wrap,
    output logic frame_last,
    output logic nxt_frame_last
);

    localparam int RW = ctr_width(SIZE);
    localparam int BW = ctr_width(WIDTH);
    localparam logic [RW-1:0] REP_LAST = RW'(SIZE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] nxt_rep;
    logic [BW-1:0] bit_idx;
    logic [BW-1:0] nxt_bit;

    // nxt_frame_last lets the top register frame_end one cycle ahead.
    always_comb begin
        rep_wrap   = (rep_cnt == REP_LAST);
        frame_last = rep_wrap && (bit_idx == BIT_LAST);
        nxt_rep    = rep_wrap ? '0 : rep_cnt + RW'(1);
        nxt_bit    = bit_idx;
        if (rep_wrap) begin
            nxt_bit = (bit_idx == BIT_LAST) ? '0 : bit_idx + BW'(1);
        end
        nxt_frame_last = (nxt_rep == REP_LAST) && (nxt_bit == BIT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            rep_cnt <= '0;
            bit_idx <= '0;
        end else if (advance) begin
            rep_cnt <= nxt_rep;
            bit_idx <= nxt_bit;
        end
    end

endmodule

// File: rtl/majority_repeat_tx.sv
// rtl/majority_repeat_tx.sv - serialises words MSB first, repeating each bit SIZE times
module majority_repeat_tx
    import majority_repeat_tx_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [SIZE-1:0]  code_word,
    output logic             code_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam logic FIRST_IS_LAST = 1'((SIZE == 1) && (WIDTH == 1));

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] nxt_shreg;
    logic             rep_wrap;
    logic             frame_last;
    logic             nxt_frame_last;
    logic             ctr_clear;
    logic             ctr_advance;

    assign ctr_clear   = (state == ST_IDLE) && in_valid;
    assign ctr_advance = (state == ST_SEND) && !frame_last;
    assign nxt_shreg   = rep_wrap ? (shreg << 1) : shreg;

    majority_repeat_ctr #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk            (clk),
        .reset          (reset),
        .clear          (ctr_clear),
        .advance        (ctr_advance),
        .rep_wrap       (rep_wrap),
        .frame_last     (frame_last),
        .nxt_frame_last (nxt_frame_last)
    );

    // Outputs are loaded with the values for the coming cycle, so they are pure flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            in_ready    <= 1'b1;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            code_word   <= '0;
            code_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state       <= ST_SEND;
                        shreg       <= in_data;
                        in_ready    <= 1'b0;
                        ser_out     <= in_data[WIDTH-1];
                        ser_valid   <= 1'b1;
                        code_word   <= {SIZE{in_data[WIDTH-1]}};
                        code_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        frame_end   <= FIRST_IS_LAST;
                    end
                end
                ST_SEND: begin
                    if (frame_last) begin
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                        ser_out     <= 1'b0;
                        ser_valid   <= 1'b0;
                        code_word   <= '0;
                        code_valid  <= 1'b0;
                        frame_start <= 1'b0;
                        frame_end   <= 1'b0;
                    end else begin
                        shreg       <= nxt_shreg;
                        ser_out     <= nxt_shreg[WIDTH-1];
                        code_word   <= {SIZE{nxt_shreg[WIDTH-1]}};
                        code_valid  <= rep_wrap;
                        frame_start <= 1'b0;
                        frame_end   <= nxt_frame_last;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_majority_repeat_tx.sv
// tb/tb_majority_repeat_tx.sv - randomized self-checking bench for majority_repeat_tx
module tb_majority_repeat_tx;

    localparam int S  = 9;
    localparam int W  = 8;
    localparam int S2 = 3;
    localparam int W2 = 4;
    localparam int FRAME = S * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, ser_out, ser_valid, code_valid, frame_start, frame_end;
    logic [S-1:0]  code_word;

    logic [W2-1:0] b_in_data = '0;
    logic          b_in_valid = 1'b0;
    logic          b_in_ready, b_ser_out, b_ser_valid, b_code_valid, b_frame_start, b_frame_end;
    logic [S2-1:0] b_code_word;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    majority_repeat_tx dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .code_word(code_word), .code_valid(code_valid),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    majority_repeat_tx #(.SIZE(S2), .WIDTH(W2)) dut_small (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
        .code_word(b_code_word), .code_valid(b_code_valid),
        .frame_start(b_frame_start), .frame_end(b_frame_end)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " ser_valid"}, 64'(ser_valid), 64'd0);
        check({tag, " ser_out"}, 64'(ser_out), 64'd0);
        check({tag, " code_word"}, 64'(code_word), 64'd0);
        check({tag, " code_valid"}, 64'(code_valid), 64'd0);
        check({tag, " frame_start"}, 64'(frame_start), 64'd0);
        check({tag, " frame_end"}, 64'(frame_end), 64'd0);
    endtask

    // Expects the accepting edge to be the next posedge. mode 0: drop in_valid,
    // mode 1: random noise on inputs, mode 2: hold in_valid with next_word.
    // Returns after checking cycle stop_at when stop_at < FRAME, else one cycle past the frame.
    task automatic run_frame(input logic [W-1:0] word, input int mode,
                             input logic [W-1:0] next_word, input int stop_at);
        logic         b;
        logic [S-1:0] mask;
        logic         voted;
        int           k;
        @(negedge clk);
        for (int idx = 0; idx < FRAME; idx++) begin
            b = word[W - 1 - idx / S];
            check("ser_valid", 64'(ser_valid), 64'd1);
            check("in_ready", 64'(in_ready), 64'd0);
            check("ser_out", 64'(ser_out), 64'(b));
            check("code_word", 64'(code_word), b ? 64'h1FF : 64'h0);
            check("code_valid", 64'(code_valid), 64'(idx % S == 0));
            check("frame_start", 64'(frame_start), 64'(idx == 0));
            check("frame_end", 64'(frame_end), 64'(idx == FRAME - 1));
            mask = '0;
            k = $urandom_range(0, 4);
            for (int t = 0; t < k; t++) mask[$urandom_range(0, S - 1)] = 1'b1;
            voted = ($countones(code_word ^ mask) >= 5);
            check("voter", 64'(voted), 64'(b));
            if (idx + 1 == stop_at && stop_at < FRAME) return;
            case (mode)
                1: begin
                    in_valid = (idx == FRAME - 1) ? 1'b0 : 1'($urandom_range(0, 1));
                    in_data  = W'($urandom);
                end
                2: begin
                    in_valid = 1'b1;
                    in_data  = next_word;
                end
                default: in_valid = 1'b0;
            endcase
            @(negedge clk);
        end
    endtask

    initial begin
        logic [W-1:0]     w;
        logic [S2*W2-1:0] small_exp;

        #12;
        check_idle("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        check_idle("after_reset");

        in_valid = 1'b1; in_data = 8'hA5;
        run_frame(8'hA5, 0, 8'h00, FRAME);
        check_idle("gap_a5");

        in_valid = 1'b1; in_data = 8'h3C;
        run_frame(8'h3C, 0, 8'h00, FRAME);
        check_idle("gap_3c");

        in_valid = 1'b1; in_data = 8'hFF;
        run_frame(8'hFF, 2, 8'h00, FRAME);
        check_idle("gap_ff");
        run_frame(8'h00, 0, 8'h00, FRAME);
        check_idle("gap_00");

        for (int f = 0; f < 4; f++) begin
            w = W'($urandom);
            in_valid = 1'b1; in_data = w;
            run_frame(w, 1, 8'h00, FRAME);
            check_idle("gap_rand");
        end

        w = W'($urandom);
        in_valid = 1'b1; in_data = w;
        run_frame(w, 0, 8'h00, 30);
        #2 reset = 1'b1;
        #1 check_idle("async_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_abort");
        w = W'($urandom);
        in_valid = 1'b1; in_data = w;
        run_frame(w, 0, 8'h00, FRAME);
        check_idle("gap_post_abort");

        small_exp = 12'b111000000111;
        b_in_valid = 1'b1; b_in_data = 4'b1001;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int idx = 0; idx < S2 * W2; idx++) begin
            check("small ser_valid", 64'(b_ser_valid), 64'd1);
            check("small ser_out", 64'(b_ser_out), 64'(small_exp[S2*W2-1-idx]));
            check("small code_word", 64'(b_code_word), small_exp[S2*W2-1-idx] ? 64'h7 : 64'h0);
            check("small code_valid", 64'(b_code_valid), 64'(idx % S2 == 0));
            check("small frame_start", 64'(b_frame_start), 64'(idx == 0));
            check("small frame_end", 64'(b_frame_end), 64'(idx == S2 * W2 - 1));
            @(negedge clk);
        end
        check("small idle ready", 64'(b_in_ready), 64'd1);
        check("small idle valid", 64'(b_ser_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
